// File: rtl/axi_burst_buf_if.sv
// AXI4 bus bundle between a burst master and the staging-buffer slave.
// Carries the AR/R and AW/W/B channels with the interconnect's _S8 names.
// Handshake rule for every channel: a beat transfers on a rising clk edge
// where VALID and READY are both high. The source keeps its payload stable
// while VALID is high and READY is low.
// Ports (modports):
//   master : drives AR*/AW*/W*/RREADY/BREADY, observes READYs, R*, B*
//   slave  : the mirror image of master
interface axi_burst_buf_if #(
    parameter int ID_W = 8
);
    logic [ID_W-1:0] ARID_S8;
    logic [31:0]     ARADDR_S8;
    logic [3:0]      ARLEN_S8;
    logic [2:0]      ARSIZE_S8;
    logic [1:0]      ARBURST_S8;
    logic            ARVALID_S8;
    logic            ARREADY_S8;

    logic [ID_W-1:0] RID_S8;
    logic [31:0]     RDATA_S8;
    logic [1:0]      RRESP_S8;
    logic            RLAST_S8;
    logic            RVALID_S8;
    logic            RREADY_S8;

    logic [ID_W-1:0] AWID_S8;
    logic [31:0]     AWADDR_S8;
    logic [3:0]      AWLEN_S8;
    logic [2:0]      AWSIZE_S8;
    logic [1:0]      AWBURST_S8;
    logic            AWVALID_S8;
    logic            AWREADY_S8;

    logic [31:0]     WDATA_S8;
    logic [3:0]      WSTRB_S8;
    logic            WLAST_S8;
    logic            WVALID_S8;
    logic            WREADY_S8;

    logic [ID_W-1:0] BID_S8;
    logic [1:0]      BRESP_S8;
    logic            BVALID_S8;
    logic            BREADY_S8;

    modport master (
        output ARID_S8, ARADDR_S8, ARLEN_S8, ARSIZE_S8, ARBURST_S8, ARVALID_S8,
        input  ARREADY_S8,
        input  RID_S8, RDATA_S8, RRESP_S8, RLAST_S8, RVALID_S8,
        output RREADY_S8,
        output AWID_S8, AWADDR_S8, AWLEN_S8, AWSIZE_S8, AWBURST_S8, AWVALID_S8,
        input  AWREADY_S8,
        output WDATA_S8, WSTRB_S8, WLAST_S8, WVALID_S8,
        input  WREADY_S8,
        input  BID_S8, BRESP_S8, BVALID_S8,
        output BREADY_S8
    );

    modport slave (
        input  ARID_S8, ARADDR_S8, ARLEN_S8, ARSIZE_S8, ARBURST_S8, ARVALID_S8,
        output ARREADY_S8,
        output RID_S8, RDATA_S8, RRESP_S8, RLAST_S8, RVALID_S8,
        input  RREADY_S8,
        input  AWID_S8, AWADDR_S8, AWLEN_S8, AWSIZE_S8, AWBURST_S8, AWVALID_S8,
        output AWREADY_S8,
        input  WDATA_S8, WSTRB_S8, WLAST_S8, WVALID_S8,
        output WREADY_S8,
        output BID_S8, BRESP_S8, BVALID_S8,
        input  BREADY_S8
    );
endinterface

// File: rtl/axi_burst_buf_slave.sv
// AXI4 burst responder in front of a DEPTH-word staging buffer.
// Serves one INCR word burst (1..16 beats) at a time, read or write.
// Ports:
//   clk       : clock, all logic on the rising edge
//   rst       : synchronous active-high reset (abandons any burst, clears buffer)
//   s         : AXI bus, slave side (AR/R and AW/W/B channels)
//   dbg_state : current FSM state (0 IDLE, 1 RD, 2 WR, 3 WRESP)
module axi_burst_buf_slave #(
    parameter int DEPTH = 64,
    parameter int ID_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    axi_burst_buf_if.slave        s,
    output logic [1:0]            dbg_state
);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, WRESP = 2'd3} state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [3:0]      beat;
    logic [3:0]      len;
    logic            err;
    logic [ID_W-1:0] rid;
    logic [ID_W-1:0] bid;
    logic [31:0]     mem [DEPTH];

    // Write wins when AW and AR are both presented in the same IDLE cycle.
    logic aw_hs;
    logic ar_hs;
    logic last_beat;
    assign aw_hs     = (state == IDLE) && s.AWVALID_S8;
    assign ar_hs     = (state == IDLE) && s.ARVALID_S8 && !s.AWVALID_S8;
    assign last_beat = (beat == len);

    assign s.AWREADY_S8 = (state == IDLE);
    assign s.ARREADY_S8 = (state == IDLE) && !s.AWVALID_S8;

    // Read data comes straight from the flop array at the pointer, so it is
    // naturally stable while RREADY stalls the beat.
    assign s.RVALID_S8 = (state == RD);
    assign s.RDATA_S8  = mem[ptr];
    assign s.RLAST_S8  = (state == RD) && last_beat;
    assign s.RID_S8    = rid;
    assign s.RRESP_S8  = 2'b00;

    assign s.WREADY_S8 = (state == WR);

    assign s.BVALID_S8 = (state == WRESP);
    assign s.BRESP_S8  = err ? 2'b10 : 2'b00;
    assign s.BID_S8    = bid;

    assign dbg_state = state;

    // Size/burst type are always treated as word INCR; low address bits and
    // bits above the buffer index alias.
    logic unused_inputs;
    assign unused_inputs = ^{s.ARSIZE_S8, s.ARBURST_S8, s.AWSIZE_S8, s.AWBURST_S8,
                             s.ARADDR_S8[1:0], s.ARADDR_S8[31:IW+2],
                             s.AWADDR_S8[1:0], s.AWADDR_S8[31:IW+2]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            beat  <= '0;
            len   <= '0;
            err   <= 1'b0;
            rid   <= '0;
            bid   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (aw_hs) begin
                        bid   <= s.AWID_S8;
                        ptr   <= s.AWADDR_S8[2 +: IW];
                        len   <= s.AWLEN_S8;
                        beat  <= '0;
                        state <= WR;
                    end else if (ar_hs) begin
                        rid   <= s.ARID_S8;
                        ptr   <= s.ARADDR_S8[2 +: IW];
                        len   <= s.ARLEN_S8;
                        beat  <= '0;
                        state <= RD;
                    end
                end
                RD: begin
                    if (s.RREADY_S8) begin
                        ptr  <= ptr + IW'(1);
                        beat <= beat + 4'd1;
                        if (last_beat) begin
                            state <= IDLE;
                        end
                    end
                end
                WR: begin
                    if (s.WVALID_S8) begin
                        for (int b = 0; b < 4; b++) begin
                            if (s.WSTRB_S8[b]) begin
                                mem[ptr][8*b +: 8] <= s.WDATA_S8[8*b +: 8];
                            end
                        end
                        ptr  <= ptr + IW'(1);
                        beat <= beat + 4'd1;
                        // Burst ends on whichever comes first: master's WLAST
                        // or the beat count; disagreement is reported as SLVERR.
                        if (s.WLAST_S8 || last_beat) begin
                            err   <= (s.WLAST_S8 != last_beat);
                            state <= WRESP;
                        end
                    end
                end
                WRESP: begin
                    if (s.BREADY_S8) begin
                        err   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_burst_buf_slave.sv
// Self-checking bench for axi_burst_buf_slave: directed scenarios plus random
// bursts, checked against a word-array model of the buffer and expected queues
// of R beats and B responses.
module tb_axi_burst_buf_slave;
    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    axi_burst_buf_if #(.ID_W(8)) bus ();

    axi_burst_buf_slave #(.DEPTH(64), .ID_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .s         (bus.slave),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model and scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_mem [64];
    logic [40:0] exp_r_q [$];   // {id, last, data}
    logic [9:0]  exp_b_q [$];   // {id, resp}
    logic [31:0] rd_cap [$];    // accepted read data, for literal checks
    logic [9:0]  b_cap [$];     // accepted responses, for literal checks
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    bit          rr_hold = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout t=%0t", name, $time);
    endtask

    // Compare process: every cycle a VALID is up the payload must equal the
    // head of the expected queue; an accepted beat pops it.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.RVALID_S8) begin
                if (exp_r_q.size() == 0) begin
                    chk("unexpected_rvalid", 32'(bus.RVALID_S8), 32'd0);
                end else begin
                    chk("rdata", bus.RDATA_S8, exp_r_q[0][31:0]);
                    chk("rlast", 32'(bus.RLAST_S8), 32'(exp_r_q[0][32]));
                    chk("rid", 32'(bus.RID_S8), 32'(exp_r_q[0][40:33]));
                    chk("rresp", 32'(bus.RRESP_S8), 32'd0);
                    if (bus.RREADY_S8) begin
                        rd_cap.push_back(bus.RDATA_S8);
                        void'(exp_r_q.pop_front());
                    end
                end
            end
            if (bus.BVALID_S8) begin
                if (exp_b_q.size() == 0) begin
                    chk("unexpected_bvalid", 32'(bus.BVALID_S8), 32'd0);
                end else begin
                    chk("bresp", 32'(bus.BRESP_S8), 32'(exp_b_q[0][1:0]));
                    chk("bid", 32'(bus.BID_S8), 32'(exp_b_q[0][9:2]));
                    if (bus.BREADY_S8) begin
                        b_cap.push_back({bus.BID_S8, bus.BRESP_S8});
                        void'(exp_b_q.pop_front());
                    end
                end
            end
        end
    end

    // Random backpressure on R and B.
    always @(posedge clk) begin
        #1;
        if (!rr_hold) bus.RREADY_S8 = ($urandom_range(0, 3) != 0);
        bus.BREADY_S8 = ($urandom_range(0, 2) != 0);
    end

    // ---------------- driver tasks ----------------
    task automatic aw_phase(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len);
        int t = 0;
        @(posedge clk); #1;
        bus.AWID_S8 = id; bus.AWADDR_S8 = addr; bus.AWLEN_S8 = len;
        bus.AWSIZE_S8 = 3'd2; bus.AWBURST_S8 = 2'd1; bus.AWVALID_S8 = 1'b1;
        @(negedge clk);
        while (!bus.AWREADY_S8 && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) timeout("awready");
        @(posedge clk); #1;
        bus.AWVALID_S8 = 1'b0;
    endtask

    // Sends the data beats of a write burst; wlast_at is the beat index that
    // carries WLAST (a value above len means WLAST is never sent).
    task automatic w_phase(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input int wlast_at);
        int nb = (wlast_at < int'(len)) ? wlast_at + 1 : int'(len) + 1;
        logic [1:0] resp = (wlast_at != int'(len)) ? 2'b10 : 2'b00;
        for (int i = 0; i < nb; i++) begin
            int t = 0;
            int idx = (int'(addr >> 2) + i) % 64;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            bus.WVALID_S8 = 1'b1; bus.WDATA_S8 = wd[i]; bus.WSTRB_S8 = ws[i];
            bus.WLAST_S8 = (i == wlast_at);
            @(negedge clk);
            while (!bus.WREADY_S8 && t < 50) begin @(negedge clk); t++; end
            if (t >= 50) timeout("wready");
            for (int b = 0; b < 4; b++) begin
                if (ws[i][b]) model_mem[idx][8*b +: 8] = wd[i][8*b +: 8];
            end
            @(posedge clk); #1;
            bus.WVALID_S8 = 1'b0; bus.WLAST_S8 = 1'b0;
        end
        exp_b_q.push_back({id, resp});
        @(negedge clk);
        chk("bvalid_after_burst", 32'(bus.BVALID_S8), 32'd1);
        chk("wready_after_burst", 32'(bus.WREADY_S8), 32'd0);
    endtask

    task automatic b_wait();
        int t = 0;
        @(negedge clk); #1;
        while (exp_b_q.size() != 0 && t < 100) begin @(negedge clk); #1; t++; end
        if (t >= 100) timeout("b_response");
    endtask

    task automatic ar_phase(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len);
        int t = 0;
        for (int i = 0; i <= int'(len); i++) begin
            exp_r_q.push_back({id, (i == int'(len)), model_mem[(int'(addr >> 2) + i) % 64]});
        end
        @(posedge clk); #1;
        bus.ARID_S8 = id; bus.ARADDR_S8 = addr; bus.ARLEN_S8 = len;
        bus.ARSIZE_S8 = 3'd2; bus.ARBURST_S8 = 2'd1; bus.ARVALID_S8 = 1'b1;
        @(negedge clk);
        while (!bus.ARREADY_S8 && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) timeout("arready");
        @(posedge clk); #1;
        bus.ARVALID_S8 = 1'b0;
        @(negedge clk);
        chk("rvalid_after_ar", 32'(bus.RVALID_S8), 32'd1);
    endtask

    task automatic r_wait();
        int t = 0;
        @(negedge clk); #1;
        while (exp_r_q.size() != 0 && t < 200) begin @(negedge clk); #1; t++; end
        if (t >= 200) timeout("r_data");
    endtask

    task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input int wlast_at);
        aw_phase(id, addr, len);
        w_phase(id, addr, len, wlast_at);
        b_wait();
    endtask

    task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len);
        ar_phase(id, addr, len);
        r_wait();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        bus.ARID_S8 = '0; bus.ARADDR_S8 = '0; bus.ARLEN_S8 = '0; bus.ARSIZE_S8 = '0;
        bus.ARBURST_S8 = '0; bus.ARVALID_S8 = 1'b0; bus.RREADY_S8 = 1'b0;
        bus.AWID_S8 = '0; bus.AWADDR_S8 = '0; bus.AWLEN_S8 = '0; bus.AWSIZE_S8 = '0;
        bus.AWBURST_S8 = '0; bus.AWVALID_S8 = 1'b0;
        bus.WDATA_S8 = '0; bus.WSTRB_S8 = '0; bus.WLAST_S8 = 1'b0; bus.WVALID_S8 = 1'b0;
        bus.BREADY_S8 = 1'b0;
        for (int i = 0; i < 64; i++) model_mem[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_state", 32'(dbg_state), 32'd0);
        chk("rst_awready", 32'(bus.AWREADY_S8), 32'd1);
        chk("rst_arready", 32'(bus.ARREADY_S8), 32'd1);
        chk("rst_rvalid", 32'(bus.RVALID_S8), 32'd0);
        chk("rst_rlast", 32'(bus.RLAST_S8), 32'd0);
        chk("rst_wready", 32'(bus.WREADY_S8), 32'd0);
        chk("rst_bvalid", 32'(bus.BVALID_S8), 32'd0);
        chk("rst_rid", 32'(bus.RID_S8), 32'd0);
        chk("rst_bid", 32'(bus.BID_S8), 32'd0);
        chk("rst_rdata", bus.RDATA_S8, 32'd0);
        chk("rst_bresp", 32'(bus.BRESP_S8), 32'd0);

        // Four-beat write then read back at 0x10
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
        b_cap.delete();
        do_write(8'h5A, 32'h10, 4'd3, 3);
        chk("t1_b_literal", 32'(b_cap.size() > 0 ? b_cap[0] : 10'h3FF), 32'({8'h5A, 2'b00}));
        rd_cap.delete();
        do_read(8'h33, 32'h10, 4'd3);
        for (int i = 0; i < 4; i++)
            chk("t1_rdata_literal", (rd_cap.size() > i) ? rd_cap[i] : 32'hDEAD, 32'hA0 + 32'(i));

        // RREADY stalled three cycles on beat 2: payload must hold
        rr_hold = 1'b1;
        bus.RREADY_S8 = 1'b1;
        ar_phase(8'h44, 32'h10, 4'd3);
        @(posedge clk); @(posedge clk); #1;
        bus.RREADY_S8 = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_rdata", bus.RDATA_S8, 32'hA2);
            chk("stall_rlast", 32'(bus.RLAST_S8), 32'd0);
        end
        bus.RREADY_S8 = 1'b1;
        r_wait();
        rr_hold = 1'b0;

        // Byte strobes merge into an existing word
        wd[0] = 32'h11223344; ws[0] = 4'hF;
        do_write(8'h01, 32'h0, 4'd0, 0);
        wd[0] = 32'hFFFFFFFF; ws[0] = 4'b0101;
        do_write(8'h02, 32'h0, 4'd0, 0);
        rd_cap.delete();
        do_read(8'h03, 32'h0, 4'd0);
        chk("strb_literal", (rd_cap.size() > 0) ? rd_cap[0] : 32'hDEAD, 32'h11FF33FF);

        // Pointer wrap: 0xF8 covers indices 62, 63, 0, 1
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hC0DE0000 + 32'(i); ws[i] = 4'hF; end
        do_write(8'h10, 32'hF8, 4'd3, 3);
        rd_cap.delete();
        do_read(8'h11, 32'hF8, 4'd3);
        for (int i = 0; i < 4; i++)
            chk("wrap_literal", (rd_cap.size() > i) ? rd_cap[i] : 32'hDEAD, 32'hC0DE0000 + 32'(i));
        rd_cap.delete();
        do_read(8'h12, 32'h0, 4'd0);
        chk("wrap_idx0_literal", (rd_cap.size() > 0) ? rd_cap[0] : 32'hDEAD, 32'hC0DE0002);

        // AW and AR together: write wins, read served after B
        @(posedge clk); #1;
        bus.AWID_S8 = 8'h21; bus.AWADDR_S8 = 32'h20; bus.AWLEN_S8 = 4'd1; bus.AWVALID_S8 = 1'b1;
        bus.ARID_S8 = 8'h22; bus.ARADDR_S8 = 32'h20; bus.ARLEN_S8 = 4'd1; bus.ARVALID_S8 = 1'b1;
        @(negedge clk);
        chk("both_awready", 32'(bus.AWREADY_S8), 32'd1);
        chk("both_arready", 32'(bus.ARREADY_S8), 32'd0);
        @(posedge clk); #1;
        bus.AWVALID_S8 = 1'b0;
        wd[0] = 32'h5555AAAA; wd[1] = 32'h12345678; ws[0] = 4'hF; ws[1] = 4'hF;
        w_phase(8'h21, 32'h20, 4'd1, 1);
        b_wait();
        do_read(8'h22, 32'h20, 4'd1);

        // Early WLAST on beat 2 of a 4-beat burst: SLVERR
        b_cap.delete();
        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(8'h77, 32'h80, 4'd3, 1);
        chk("early_wlast_literal", 32'(b_cap.size() > 0 ? b_cap[0] : 10'h3FF), 32'({8'h77, 2'b10}));
        do_read(8'h78, 32'h80, 4'd3);

        // Reset during the third write beat
        aw_phase(8'h66, 32'h40, 4'd3);
        for (int i = 0; i < 2; i++) begin
            int t = 0;
            bus.WVALID_S8 = 1'b1; bus.WDATA_S8 = 32'hBEEF0000 + 32'(i); bus.WSTRB_S8 = 4'hF;
            @(negedge clk);
            while (!bus.WREADY_S8 && t < 50) begin @(negedge clk); t++; end
            if (t >= 50) timeout("rst_wready");
            @(posedge clk); #1;
        end
        bus.WDATA_S8 = 32'hBEEF0002;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus.WVALID_S8 = 1'b0;
        for (int i = 0; i < 64; i++) model_mem[i] = '0;
        exp_r_q.delete(); exp_b_q.delete();
        @(negedge clk);
        chk("midrst_state", 32'(dbg_state), 32'd0);
        chk("midrst_rvalid", 32'(bus.RVALID_S8), 32'd0);
        chk("midrst_bvalid", 32'(bus.BVALID_S8), 32'd0);
        chk("midrst_wready", 32'(bus.WREADY_S8), 32'd0);
        rd_cap.delete();
        do_read(8'h67, 32'h40, 4'd3);
        for (int i = 0; i < 4; i++)
            chk("midrst_literal", (rd_cap.size() > i) ? rd_cap[i] : 32'hDEAD, 32'd0);

        // Random bursts against the model
        for (int n = 0; n < 40; n++) begin
            logic [31:0] addr = $urandom;
            logic [3:0]  len  = 4'($urandom_range(0, 15));
            logic [7:0]  id   = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                int r = $urandom_range(0, 9);
                int wl;
                for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
                if (r < 7) wl = int'(len);
                else if (r == 7 && len != 0) wl = $urandom_range(0, int'(len) - 1);
                else wl = 16;
                do_write(id, addr, len, wl);
            end else begin
                do_read(id, addr, len);
            end
        end

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
